// File: rtl/prio_scan_encoder.sv
// Sequential priority scan encoder: captures a request vector and emits one set-bit index per
// handshake. Define SCAN_LSB_FIRST_EN to emit ascending indices instead of descending.
module prio_scan_encoder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned POS_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [POS_W-1:0] out_pos,
   output logic             out_last,
   output logic [POS_W:0]   out_cnt
);

   typedef enum logic [0:0] {StIdle, StScan} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [POS_W-1:0] pos;
   logic [POS_W:0]   cnt;

   // Priority pick over the remaining bits; the last match in loop order wins.
   always_comb begin
      pos = '0;
`ifdef SCAN_LSB_FIRST_EN
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (rem_q[i]) pos = POS_W'(i);
      end
`else
      for (int i = 0; i < WIDTH; i++) begin
         if (rem_q[i]) pos = POS_W'(i);
      end
`endif
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt = cnt + {{POS_W{1'b0}}, rem_q[i]};
      end
   end

   // rem_q is zero whenever the block is idle, so these are naturally zero there.
   assign out_pos   = pos;
   assign out_cnt   = cnt;
   assign out_last  = (cnt == {{POS_W{1'b0}}, 1'b1});
   assign out_valid = (state_q == StScan);
   assign in_ready  = (state_q == StIdle) && rst_n;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      unique case (state_q)
         StIdle: begin
            // A zero vector is accepted and dropped without leaving idle.
            if (in_valid && in_ready && (in_vec != '0)) begin
               rem_d   = in_vec;
               state_d = StScan;
            end
         end
         StScan: begin
            if (out_ready) begin
               rem_d = rem_q & ~({{(WIDTH - 1){1'b0}}, 1'b1} << pos);
               if (out_last) state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            rem_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   a_pos_is_set: assert property (@(posedge clk) disable iff (!rst_n)
      out_valid |-> rem_q[out_pos]);

   a_hold_under_backpressure: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> ($stable(rem_q) && out_valid));

   a_idle_is_empty: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == StIdle) |-> (rem_q == '0));

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Directed self-checking bench for prio_scan_encoder at WIDTH=8 and WIDTH=16.
module tb_prio_scan_encoder;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid, in_ready, out_valid, out_ready, out_last;
   logic [7:0]  in_vec;
   logic [2:0]  out_pos;
   logic [3:0]  out_cnt;

   logic        in_valid16, in_ready16, out_valid16, out_ready16, out_last16;
   logic [15:0] in_vec16;
   logic [3:0]  out_pos16;
   logic [4:0]  out_cnt16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   prio_scan_encoder #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pos   (out_pos),
      .out_last  (out_last),
      .out_cnt   (out_cnt)
   );

   prio_scan_encoder #(.WIDTH(16)) dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid16),
      .in_ready  (in_ready16),
      .in_vec    (in_vec16),
      .out_valid (out_valid16),
      .out_ready (out_ready16),
      .out_pos   (out_pos16),
      .out_last  (out_last16),
      .out_cnt   (out_cnt16)
   );

   // Advance one edge; inputs driven and outputs sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_vec = 'x; out_ready = 1'b0;
      in_valid16 = 1'b0; in_vec16 = 'x; out_ready16 = 1'b0;
      tick(); tick();
      checks++;
      if ({out_valid, out_pos, out_last, out_cnt} !== 9'd0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b pos=%0d last=%b cnt=%0d, expected all zero",
                  out_valid, out_pos, out_last, out_cnt);
      end
      checks++;
      if ({out_valid16, out_pos16, out_last16, out_cnt16} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs16: got v=%b pos=%0d last=%b cnt=%0d, expected all zero",
                  out_valid16, out_pos16, out_last16, out_cnt16);
      end
      rst_n = 1'b1;
      #1;
      in_valid = 1'b1; in_vec = 8'h00;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_vector[%0d]: got in_ready=%b out_valid=%b, expected 1 0",
                     k, in_ready, out_valid);
         end
         tick();
      end
      in_valid = 1'b0; in_vec = 'x;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_cnt !== 4'd0) begin
         errors++;
         $display("FAIL zero_vector_after: got in_ready=%b out_valid=%b cnt=%0d, expected 1 0 0",
                  in_ready, out_valid, out_cnt);
      end
   endtask

   task automatic test_basic_scan();
      int seq[4];
`ifdef SCAN_LSB_FIRST_EN
      seq = '{1, 2, 5, 7};
`else
      seq = '{7, 5, 2, 1};
`endif
      in_valid = 1'b1; in_vec = 8'b1010_0110; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; in_vec = 'x;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_pos !== 3'(seq[k]) ||
             out_cnt !== 4'(4 - k) || out_last !== (k == 3)) begin
            errors++;
            $display("FAIL basic_scan[%0d]: got v=%b rdy=%b pos=%0d cnt=%0d last=%b, expected 1 0 %0d %0d %b",
                     k, out_valid, in_ready, out_pos, out_cnt, out_last, seq[k], 4 - k, k == 3);
         end
         tick();
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle: got in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_backpressure();
      int first, second;
`ifdef SCAN_LSB_FIRST_EN
      first = 0; second = 7;
`else
      first = 7; second = 0;
`endif
      in_valid = 1'b1; in_vec = 8'h81; out_ready = 1'b0;
      tick();
      in_valid = 1'b0; in_vec = 'x;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (out_valid !== 1'b1 || out_pos !== 3'(first) || out_cnt !== 4'd2 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold[%0d]: got v=%b pos=%0d cnt=%0d last=%b, expected 1 %0d 2 0",
                     k, out_valid, out_pos, out_cnt, out_last, first);
         end
         tick();
      end
      out_ready = 1'b1;
      checks++;
      if (out_pos !== 3'(first) || out_cnt !== 4'd2) begin
         errors++;
         $display("FAIL backpressure_release: got pos=%0d cnt=%0d, expected %0d 2", out_pos, out_cnt, first);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pos !== 3'(second) || out_cnt !== 4'd1 || out_last !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_second: got v=%b pos=%0d cnt=%0d last=%b, expected 1 %0d 1 1",
                  out_valid, out_pos, out_cnt, out_last, second);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_idle: got out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_width16();
      int exp_pos;
      in_valid16 = 1'b1; in_vec16 = 16'hFFFF; out_ready16 = 1'b1;
      tick();
      in_valid16 = 1'b0; in_vec16 = 'x;
      for (int k = 0; k < 16; k++) begin
`ifdef SCAN_LSB_FIRST_EN
         exp_pos = k;
`else
         exp_pos = 15 - k;
`endif
         checks++;
         if (out_valid16 !== 1'b1 || out_pos16 !== 4'(exp_pos) || out_cnt16 !== 5'(16 - k) ||
             out_last16 !== (k == 15)) begin
            errors++;
            $display("FAIL width16[%0d]: got v=%b pos=%0d cnt=%0d last=%b, expected 1 %0d %0d %b",
                     k, out_valid16, out_pos16, out_cnt16, out_last16, exp_pos, 16 - k, k == 15);
         end
         tick();
      end
      checks++;
      if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
         errors++;
         $display("FAIL width16_idle: got out_valid=%b in_ready=%b, expected 0 1", out_valid16, in_ready16);
      end
   endtask

   task automatic test_reset_midscan();
      int first;
`ifdef SCAN_LSB_FIRST_EN
      first = 4;
`else
      first = 7;
`endif
      in_valid = 1'b1; in_vec = 8'hF0; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; in_vec = 'x;
      checks++;
      if (out_valid !== 1'b1 || out_pos !== 3'(first) || out_cnt !== 4'd4) begin
         errors++;
         $display("FAIL midscan_first: got v=%b pos=%0d cnt=%0d, expected 1 %0d 4",
                  out_valid, out_pos, out_cnt, first);
      end
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_cnt !== 4'd0 || out_pos !== 3'd0) begin
         errors++;
         $display("FAIL midscan_reset: got v=%b rdy=%b cnt=%0d pos=%0d, expected 0 1 0 0",
                  out_valid, in_ready, out_cnt, out_pos);
      end
      in_valid = 1'b1; in_vec = 8'h01;
      tick();
      in_valid = 1'b0; in_vec = 'x;
      checks++;
      if (out_valid !== 1'b1 || out_pos !== 3'd0 || out_cnt !== 4'd1 || out_last !== 1'b1) begin
         errors++;
         $display("FAIL midscan_single: got v=%b pos=%0d cnt=%0d last=%b, expected 1 0 1 1",
                  out_valid, out_pos, out_cnt, out_last);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midscan_idle: got out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
      end
   endtask

   // in_valid stays high across the final handshake: the next vector must wait one idle cycle,
   // and changing in_vec during the scan must not disturb it.
   task automatic test_back_to_back();
      out_ready = 1'b1;
      in_valid = 1'b1; in_vec = 8'h04;
      tick();
      in_vec = 8'h10;
      checks++;
      if (out_valid !== 1'b1 || out_pos !== 3'd2 || out_cnt !== 4'd1 || out_last !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: got v=%b pos=%0d cnt=%0d last=%b, expected 1 2 1 1",
                  out_valid, out_pos, out_cnt, out_last);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_gap: got out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
      end
      tick();
      in_valid = 1'b0; in_vec = 'x;
      checks++;
      if (out_valid !== 1'b1 || out_pos !== 3'd4 || out_cnt !== 4'd1 || out_last !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second: got v=%b pos=%0d cnt=%0d last=%b, expected 1 4 1 1",
                  out_valid, out_pos, out_cnt, out_last);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_idle: got out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_basic_scan();
      test_backpressure();
      test_width16();
      test_reset_midscan();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
